// File: rtl/load_v_stream_pkg.sv
// Shared types and helpers for the load_v_stream tile loader.
package load_v_stream_pkg;

    // Width of one element in bits; the loader moves bytes.
    localparam int unsigned ELEM_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_PRESENT,
        ST_DONE
    } state_e;

    // Number of tiles needed to hold len elements (ceiling division).
    function automatic int unsigned num_tiles(input int unsigned len, input int unsigned tile_elems);
        return (len + tile_elems - 1) / tile_elems;
    endfunction

endpackage

// File: rtl/load_v_stream_rd_lat_pipe.sv
// Fixed-latency tracker of issued reads: {valid, beat index} delayed by LATENCY cycles.
module load_v_stream_rd_lat_pipe #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned IDX_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [LATENCY-1:0]            valid_q;
    logic [LATENCY-1:0][IDX_W-1:0] idx_q;

    // Shift register; reset flushes every in-flight read so late data is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else begin
            valid_q[0] <= valid_i;
            idx_q[0]   <= idx_i;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                idx_q[s]   <= idx_q[s-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign idx_o   = idx_q[LATENCY-1];

endmodule

// File: rtl/load_v_stream.sv
// Vector load streamer: fetches length bytes from DRAM in BEAT_BYTES beats and
// streams zero-padded TILE_ELEMS-element tiles over valid/ready.
// Optional stall counter output enabled by LOAD_V_STREAM_STALL_CNT_EN.
module load_v_stream
    import load_v_stream_pkg::*;
#(
    parameter int unsigned TILE_ELEMS  = 32,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BEAT_BYTES  = 4,
    parameter int unsigned ADDR_WIDTH  = 24,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_valid,
    output logic                             start_ready,
    input  logic [ADDR_WIDTH-1:0]            dram_addr,
    input  logic [LEN_WIDTH-1:0]             length,
    output logic                             mem_rd_en,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [BEAT_BYTES*8-1:0]          mem_rdata,
    output logic [TILE_ELEMS*DATA_WIDTH-1:0] tile_data,
    output logic                             tile_valid,
    input  logic                             tile_ready,
    output logic                             tile_last,
    output logic                             done,
    output logic                             busy,
    output logic                             err_misaligned
`ifdef LOAD_V_STREAM_STALL_CNT_EN
    ,
    output logic [31:0]                      stall_cycles
`endif
);

    localparam int unsigned BEATS  = TILE_ELEMS / BEAT_BYTES;
    localparam int unsigned BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned EIDX_W = LEN_WIDTH + 1;
    localparam int unsigned TILE_W = TILE_ELEMS * DATA_WIDTH;

    if (DATA_WIDTH != ELEM_BITS) begin : g_bad_data_width
        $fatal(1, "load_v_stream: DATA_WIDTH must be 8");
    end

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [EIDX_W-1:0]       base_q, base_d;
    logic [EIDX_W-1:0]       tiles_q, tiles_d;
    logic [BIDX_W-1:0]       beat_q, beat_d;
    logic [TILE_W-1:0]       tile_q, tile_d;
    logic                    rd_en_q, rd_en_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    sready_q, sready_d;
    logic                    busy_q, busy_d;
    logic                    pipe_valid;
    logic [BIDX_W-1:0]       pipe_idx;
    logic                    misaligned_c;

    load_v_stream_rd_lat_pipe #(
        .LATENCY (MEM_LATENCY),
        .IDX_W   (BIDX_W)
    ) u_rd_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd_en_q),
        .idx_i   (beat_q),
        .valid_o (pipe_valid),
        .idx_o   (pipe_idx)
    );

    assign misaligned_c = (dram_addr % ADDR_WIDTH'(BEAT_BYTES)) != '0;

    // Next-state, tile capture and registered-output decode.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        base_d   = base_q;
        tiles_d  = tiles_q;
        beat_d   = beat_q;
        tile_d   = tile_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_valid) begin
                    addr_d  = dram_addr;
                    len_d   = length;
                    base_d  = '0;
                    beat_d  = '0;
                    tiles_d = EIDX_W'(num_tiles(32'(length), TILE_ELEMS));
                    if (misaligned_c) begin
                        err_d = 1'b1;
                    end else if (length == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                addr_d = addr_q + ADDR_WIDTH'(BEAT_BYTES);
                beat_d = beat_q + BIDX_W'(1);
                if (beat_q == BIDX_W'(BEATS - 1)) begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (pipe_valid && (pipe_idx == BIDX_W'(BEATS - 1))) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (tile_ready) begin
                    tiles_d = tiles_q - EIDX_W'(1);
                    if (tiles_q == EIDX_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                        base_d  = base_q + EIDX_W'(TILE_ELEMS);
                        beat_d  = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Returning beat lands in its slot; elements past the command length read as zero.
        if (pipe_valid) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (pipe_idx == BIDX_W'(b)) begin
                    for (int unsigned i = 0; i < BEAT_BYTES; i++) begin
                        tile_d[(b*BEAT_BYTES+i)*ELEM_BITS +: ELEM_BITS] =
                            ((base_q + EIDX_W'(b*BEAT_BYTES+i)) < EIDX_W'(len_q)) ?
                            mem_rdata[i*ELEM_BITS +: ELEM_BITS] : '0;
                    end
                end
            end
        end

        rd_en_d  = (state_d == ST_FETCH);
        tvalid_d = (state_d == ST_PRESENT);
        tlast_d  = (state_d == ST_PRESENT) && (tiles_d == EIDX_W'(1));
        done_d   = (state_d == ST_DONE);
        sready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            base_q   <= '0;
            tiles_q  <= '0;
            beat_q   <= '0;
            tile_q   <= '0;
            rd_en_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sready_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            base_q   <= base_d;
            tiles_q  <= tiles_d;
            beat_q   <= beat_d;
            tile_q   <= tile_d;
            rd_en_q  <= rd_en_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sready_q <= sready_d;
            busy_q   <= busy_d;
        end
    end

    assign start_ready    = sready_q;
    assign mem_rd_en      = rd_en_q;
    assign mem_addr       = addr_q;
    assign tile_data      = tile_q;
    assign tile_valid     = tvalid_q;
    assign tile_last      = tlast_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign err_misaligned = err_q;

`ifdef LOAD_V_STREAM_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of backpressured presentation cycles, cleared per command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (sready_q && start_valid) begin
            stall_q <= '0;
        end else if (tvalid_q && !tile_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_load_v_stream.sv
// Scoreboard bench for load_v_stream: instance A uses MEM_LATENCY=1, instance B uses 3.
module tb_load_v_stream;

    typedef struct packed {
        logic [255:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    logic [23:0] dram_addr = '0;
    logic [15:0] length = '0;
    logic        tile_ready = 1'b0;
    logic        sv_a = 1'b0, sv_b = 1'b0;

    logic        sr_a, rd_a, tv_a, tl_a, done_a, busy_a, err_a;
    logic [23:0] ma_a;
    logic [31:0] rdata_a;
    logic [255:0] td_a;
    logic        sr_b, rd_b, tv_b, tl_b, done_b, busy_b, err_b;
    logic [23:0] ma_b;
    logic [31:0] rdata_b;
    logic [255:0] td_b;
`ifdef LOAD_V_STREAM_STALL_CNT_EN
    logic [31:0] stall_a, stall_b;
`endif

    load_v_stream #(.MEM_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst), .start_valid(sv_a), .start_ready(sr_a),
        .dram_addr(dram_addr), .length(length), .mem_rd_en(rd_a), .mem_addr(ma_a),
        .mem_rdata(rdata_a), .tile_data(td_a), .tile_valid(tv_a), .tile_ready(tile_ready),
        .tile_last(tl_a), .done(done_a), .busy(busy_a), .err_misaligned(err_a)
`ifdef LOAD_V_STREAM_STALL_CNT_EN
        , .stall_cycles(stall_a)
`endif
    );

    load_v_stream #(.MEM_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst), .start_valid(sv_b), .start_ready(sr_b),
        .dram_addr(dram_addr), .length(length), .mem_rd_en(rd_b), .mem_addr(ma_b),
        .mem_rdata(rdata_b), .tile_data(td_b), .tile_valid(tv_b), .tile_ready(tile_ready),
        .tile_last(tl_b), .done(done_b), .busy(busy_b), .err_misaligned(err_b)
`ifdef LOAD_V_STREAM_STALL_CNT_EN
        , .stall_cycles(stall_b)
`endif
    );

    // Memory contents are a fixed function of the byte address.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    // Memory models; invalid cycles return 0xEE so mistimed captures show up.
    logic        mv_a = 1'b0;
    logic [23:0] mq_a = '0;
    logic [2:0]  mv_b = '0;
    logic [23:0] mq_b [3];
    always @(posedge clk) begin
        mv_a    <= rd_a;
        mq_a    <= ma_a;
        mv_b    <= {mv_b[1:0], rd_b};
        mq_b[2] <= mq_b[1];
        mq_b[1] <= mq_b[0];
        mq_b[0] <= ma_b;
    end
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdata_a[i*8 +: 8] = mv_a ? mem_byte(mq_a + 24'(i)) : 8'hEE;
            rdata_b[i*8 +: 8] = mv_b[2] ? mem_byte(mq_b[2] + 24'(i)) : 8'hEE;
        end
    end

    exp_t        sb_a[$], sb_b[$];
    logic [23:0] exp_addr_a = '0, exp_addr_b = '0;
    int          rd_cnt_a = 0, rd_cnt_b = 0, tv_cnt_a = 0;

    // Instance A monitor: read addresses and tile handshakes against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rd_a) begin
                checks++;
                rd_cnt_a++;
                if (ma_a !== exp_addr_a) begin
                    failures++;
                    $display("FAIL rd_addr_a got=%h exp=%h", ma_a, exp_addr_a);
                end
                exp_addr_a += 24'd4;
            end
            if (tv_a) tv_cnt_a++;
            if (tv_a && tile_ready) begin
                checks++;
                if (sb_a.size() == 0) begin
                    failures++;
                    $display("FAIL tile_a unexpected tile got last=%b", tl_a);
                end else begin
                    e = sb_a.pop_front();
                    if (td_a !== e.data || tl_a !== e.last) begin
                        failures++;
                        $display("FAIL tile_a got=%h last=%b exp=%h last=%b", td_a, tl_a, e.data, e.last);
                    end
                end
            end
        end
    end

    // Instance B monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rd_b) begin
                checks++;
                rd_cnt_b++;
                if (ma_b !== exp_addr_b) begin
                    failures++;
                    $display("FAIL rd_addr_b got=%h exp=%h", ma_b, exp_addr_b);
                end
                exp_addr_b += 24'd4;
            end
            if (tv_b && tile_ready) begin
                checks++;
                if (sb_b.size() == 0) begin
                    failures++;
                    $display("FAIL tile_b unexpected tile got last=%b", tl_b);
                end else begin
                    e = sb_b.pop_front();
                    if (td_b !== e.data || tl_b !== e.last) begin
                        failures++;
                        $display("FAIL tile_b got=%h last=%b exp=%h last=%b", td_b, tl_b, e.data, e.last);
                    end
                end
            end
        end
    end

    // Drive one command for a single cycle and push its expected tiles.
    task automatic issue(input bit to_b, input logic [23:0] a, input logic [15:0] n, output int t_acc);
        int ntiles;
        exp_t e;
        @(posedge clk);
        #1;
        dram_addr = a;
        length    = n;
        if (to_b) sv_b = 1'b1; else sv_a = 1'b1;
        t_acc = cyc;
        if (to_b) begin exp_addr_b = a; rd_cnt_b = 0; end
        else begin exp_addr_a = a; rd_cnt_a = 0; tv_cnt_a = 0; end
        if (a[1:0] == 2'b00 && n != 16'd0) begin
            ntiles = (int'(n) + 31) / 32;
            for (int t = 0; t < ntiles; t++) begin
                for (int k = 0; k < 32; k++)
                    e.data[k*8 +: 8] = (t*32 + k < int'(n)) ? mem_byte(a + 24'(t*32 + k)) : 8'h00;
                e.last = (t == ntiles - 1);
                if (to_b) sb_b.push_back(e); else sb_a.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        sv_a = 1'b0;
        sv_b = 1'b0;
    endtask

    // Observe one command to completion (bounded); records event cycles only.
    task automatic wait_done(input bit on_b, input int t_acc, output int first_tv, output int hs,
                             output int done_c, output logic sr_t1, output logic sr_dn, output logic tv_dn);
        logic tv, dn;
        first_tv = -1; hs = -1; done_c = -1;
        sr_t1 = 1'bx; sr_dn = 1'bx; tv_dn = 1'bx;
        for (int k = 0; k < 80 && done_c < 0; k++) begin
            @(negedge clk);
            tv = on_b ? tv_b : tv_a;
            dn = on_b ? done_b : done_a;
            if (cyc == t_acc + 1) sr_t1 = on_b ? sr_b : sr_a;
            if (tv && first_tv < 0) first_tv = cyc;
            if (tv && tile_ready) hs = cyc;
            if (dn) begin
                done_c = cyc;
                sr_dn  = on_b ? sr_b : sr_a;
                tv_dn  = tv;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sr_a, rd_a, tv_a, tl_a, done_a, busy_a, err_a} !== 7'b1000000 || td_a !== '0) begin
            failures++;
            $display("FAIL reset_a got=%b data=%h exp=1000000 data=0",
                     {sr_a, rd_a, tv_a, tl_a, done_a, busy_a, err_a}, td_a);
        end
        checks++;
        if ({sr_b, rd_b, tv_b, tl_b, done_b, busy_b, err_b} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_b got=%b exp=1000000", {sr_b, rd_b, tv_b, tl_b, done_b, busy_b, err_b});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_tile();
        int t, ftv, hs, dc;
        logic s1, sd, td;
        tile_ready = 1'b1;
        issue(1'b0, 24'h000100, 16'd32, t);
        wait_done(1'b0, t, ftv, hs, dc, s1, sd, td);
        checks++;
        if (dc < 0) begin failures++; $display("FAIL single_timeout no done"); end
        checks++;
        if (ftv !== t + 10) begin failures++; $display("FAIL single_tv_latency got=%0d exp=%0d", ftv - t, 10); end
        checks++;
        if (dc !== hs + 1) begin failures++; $display("FAIL single_done_cycle got=%0d exp=%0d", dc, hs + 1); end
        checks++;
        if (rd_cnt_a !== 8) begin failures++; $display("FAIL single_reads got=%0d exp=8", rd_cnt_a); end
        checks++;
        if (s1 !== 1'b0) begin failures++; $display("FAIL single_busy_ready got=%b exp=0", s1); end
        checks++;
        if (sd !== 1'b1 || td !== 1'b0) begin
            failures++;
            $display("FAIL single_at_done got ready=%b valid=%b exp ready=1 valid=0", sd, td);
        end
        checks++;
        if (sb_a.size() != 0) begin failures++; $display("FAIL single_tiles_left got=%0d exp=0", sb_a.size()); end
    endtask

    task automatic test_two_tiles();
        int t, ftv, hs, dc;
        logic s1, sd, td;
        tile_ready = 1'b1;
        issue(1'b0, 24'h000100, 16'd40, t);
        wait_done(1'b0, t, ftv, hs, dc, s1, sd, td);
        checks++;
        if (dc < 0) begin failures++; $display("FAIL two_timeout no done"); end
        checks++;
        if (rd_cnt_a !== 16) begin failures++; $display("FAIL two_reads got=%0d exp=16", rd_cnt_a); end
        checks++;
        if (ftv !== t + 10 || dc !== hs + 1) begin
            failures++;
            $display("FAIL two_timing got tv=%0d done=%0d exp tv=%0d done=%0d", ftv, dc, t + 10, hs + 1);
        end
        checks++;
        if (sb_a.size() != 0) begin failures++; $display("FAIL two_tiles_left got=%0d exp=0", sb_a.size()); end
    endtask

    task automatic test_backpressure();
        int t, v;
        logic [255:0] held;
        tile_ready = 1'b0;
        issue(1'b0, 24'h000200, 16'd32, t);
        v = -1;
        for (int k = 0; k < 30 && v < 0; k++) begin
            @(negedge clk);
            if (tv_a) v = cyc;
        end
        checks++;
        if (v !== t + 10) begin failures++; $display("FAIL bp_tv_latency got=%0d exp=%0d", v - t, 10); end
        held = td_a;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (tv_a !== 1'b1 || td_a !== held || rd_a !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got valid=%b rd=%b data_stable=%b exp valid=1 rd=0 data_stable=1",
                         k, tv_a, rd_a, td_a === held);
            end
        end
        @(posedge clk);
        #1;
        tile_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (tv_a !== 1'b1) begin failures++; $display("FAIL bp_handshake got valid=%b exp=1", tv_a); end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || tv_a !== 1'b0) begin
            failures++;
            $display("FAIL bp_done got done=%b valid=%b exp done=1 valid=0", done_a, tv_a);
        end
`ifdef LOAD_V_STREAM_STALL_CNT_EN
        checks++;
        if (stall_a !== 32'd5) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=5", stall_a); end
`endif
        checks++;
        if (sb_a.size() != 0) begin failures++; $display("FAIL bp_tiles_left got=%0d exp=0", sb_a.size()); end
    endtask

    task automatic test_len_zero();
        int t;
        tile_ready = 1'b1;
        issue(1'b0, 24'h000300, 16'd0, t);
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done_a); end
        repeat (8) @(negedge clk);
        checks++;
        if (rd_cnt_a !== 0 || tv_cnt_a !== 0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL zero_quiet got reads=%0d valids=%0d done=%b exp 0 0 0", rd_cnt_a, tv_cnt_a, done_a);
        end
    endtask

    task automatic test_misaligned();
        int t;
        issue(1'b0, 24'h000102, 16'd32, t);
        @(negedge clk);
        checks++;
        if (err_a !== 1'b1 || sr_a !== 1'b1 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL mis_pulse got err=%b ready=%b done=%b exp 1 1 0", err_a, sr_a, done_a);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (err_a !== 1'b0 || rd_cnt_a !== 0 || busy_a !== 1'b0 || sr_a !== 1'b1) begin
            failures++;
            $display("FAIL mis_after got err=%b reads=%0d busy=%b ready=%b exp 0 0 0 1", err_a, rd_cnt_a, busy_a, sr_a);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int t, ftv, hs, dc;
        logic s1, sd, td;
        tile_ready = 1'b1;
        issue(1'b1, 24'h000400, 16'd32, t);
        @(negedge clk);
        checks++;
        if (rd_b !== 1'b1) begin failures++; $display("FAIL rmf_fetching got rd=%b exp=1", rd_b); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({sr_b, rd_b, tv_b, tl_b, done_b, busy_b, err_b} !== 7'b1000000) begin
            failures++;
            $display("FAIL rmf_reset_state got=%b exp=1000000", {sr_b, rd_b, tv_b, tl_b, done_b, busy_b, err_b});
        end
        sb_b.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b1, 24'h000500, 16'd32, t);
        wait_done(1'b1, t, ftv, hs, dc, s1, sd, td);
        checks++;
        if (dc < 0) begin failures++; $display("FAIL rmf_timeout no done"); end
        checks++;
        if (ftv !== t + 12) begin failures++; $display("FAIL rmf_tv_latency got=%0d exp=%0d", ftv - t, 12); end
        checks++;
        if (rd_cnt_b !== 8 || sb_b.size() != 0) begin
            failures++;
            $display("FAIL rmf_reload got reads=%0d tiles_left=%0d exp 8 0", rd_cnt_b, sb_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_two_tiles();
        test_backpressure();
        test_len_zero();
        test_misaligned();
        test_reset_mid_fetch();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
